// File: rtl/fifo_sync_flags_pkg.sv
// Shared definitions for the flagged synchronous FIFO.
// Provides the depth derivation, default almost-full/almost-empty thresholds
// and the occupancy counter width used by the top and the storage sub-module.
package fifo_sync_flags_pkg;

  // Number of words addressed by a w-bit pointer.
  function automatic int depth_of(input int w);
    return 1 << w;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int cnt_width(input int w);
    return w + 1;
  endfunction

  // Default almost_full threshold: two words short of full.
  function automatic int af_default(input int w);
    return depth_of(w) - 2;
  endfunction

  localparam int AE_DEFAULT = 2;

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer bundle for fifo_sync_flags.
// slave  : FIFO side (takes wr/rd/flush/clr_err, drives data, flags, count).
// master : user side (the mirror image).
interface fifo_sync_flags_if #(
  parameter int B = 8,
  parameter int W = 4
);
  logic         flush_i;
  logic         wr;
  logic [B-1:0] w_data;
  logic         rd;
  logic [B-1:0] r_data;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;
  logic         clr_err_i;

  modport slave (
    input  flush_i, wr, w_data, rd, clr_err_i,
    output r_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport master (
    output flush_i, wr, w_data, rd, clr_err_i,
    input  r_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags_ram.sv
// B x 2**W storage for fifo_sync_flags.
// Ports: clk; write port we/waddr/wdata (synchronous);
//        read port raddr/rdata (asynchronous, gives show-ahead head word).
// Contents are never reset.
module fifo_sync_flags_ram
  import fifo_sync_flags_pkg::*;
#(
  parameter int B = 8,
  parameter int W = 4
)(
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [B-1:0] wdata,
  input  logic [W-1:0] raddr,
  output logic [B-1:0] rdata
);
  localparam int DEPTH = depth_of(W);

  logic [B-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_flags.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds,
// synchronous flush and sticky overflow/underflow flags.
// Ports: clk, rst_i (sync, active-high, highest priority);
//        f : slave modport carrying wr/w_data, rd/r_data, flush_i, clr_err_i,
//            full, empty, almost_full, almost_empty, count, overflow, underflow.
// All flags are registered from the next-state count so they move on the
// same edge as count.
module fifo_sync_flags
  import fifo_sync_flags_pkg::*;
#(
  parameter int B         = 8,
  parameter int W         = 4,
  parameter int AF_THRESH = af_default(W),
  parameter int AE_THRESH = AE_DEFAULT
)(
  input  logic              clk,
  input  logic              rst_i,
  fifo_sync_flags_if.slave  f
);
  localparam int DEPTH = depth_of(W);
  localparam int CW    = cnt_width(W);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF_THRESH);
  localparam cnt_t AE_C    = cnt_t'(AE_THRESH);
  localparam cnt_t CNT_ONE = cnt_t'(1);

  logic [W-1:0] w_ptr, r_ptr;
  cnt_t         count_q, count_nx;
  logic         full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic         rd_acc, wr_acc, rd_go, wr_go, ovf_set, unf_set;

  // Acceptance from registered state. A write into a full FIFO is fine when
  // a read frees the head slot on the same edge. Flush overrides both.
  always_comb begin
    rd_acc  = f.rd & ~empty_q;
    wr_acc  = f.wr & (~full_q | rd_acc);
    rd_go   = rd_acc & ~f.flush_i;
    wr_go   = wr_acc & ~f.flush_i;
    ovf_set = f.wr & ~wr_acc & ~f.flush_i;
    unf_set = f.rd & empty_q & ~f.flush_i;

    count_nx = count_q;
    if (f.flush_i)           count_nx = '0;
    else if (wr_go & ~rd_go) count_nx = count_q + CNT_ONE;
    else if (rd_go & ~wr_go) count_nx = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= (AF_THRESH == 0);
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (f.flush_i) begin
        w_ptr <= '0;
        r_ptr <= '0;
      end else begin
        if (wr_go) w_ptr <= w_ptr + W'(1);
        if (rd_go) r_ptr <= r_ptr + W'(1);
      end
      count_q <= count_nx;
      full_q  <= (count_nx == DEPTH_C);
      empty_q <= (count_nx == '0);
      af_q    <= (count_nx >= AF_C);
      ae_q    <= (count_nx <= AE_C);
      // Set beats clear when both happen on one edge.
      if (ovf_set)          ovf_q <= 1'b1;
      else if (f.clr_err_i) ovf_q <= 1'b0;
      if (unf_set)          unf_q <= 1'b1;
      else if (f.clr_err_i) unf_q <= 1'b0;
    end
  end

  fifo_sync_flags_ram #(.B(B), .W(W)) u_ram (
    .clk   (clk),
    .we    (wr_go),
    .waddr (w_ptr),
    .wdata (f.w_data),
    .raddr (r_ptr),
    .rdata (f.r_data)
  );

  assign f.count        = count_q;
  assign f.full         = full_q;
  assign f.empty        = empty_q;
  assign f.almost_full  = af_q;
  assign f.almost_empty = ae_q;
  assign f.overflow     = ovf_q;
  assign f.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed self-checking bench for fifo_sync_flags (B=8, W=4, AF=14, AE=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Flag vector order: {full, empty, almost_full, almost_empty, overflow, underflow}.
module tb_fifo_sync_flags;
  localparam int B = 8;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  fifo_sync_flags_if #(.B(B), .W(W)) f();
  fifo_sync_flags #(.B(B), .W(W)) dut (.clk(clk), .rst_i(rst_i), .f(f));

  int checks   = 0;
  int failures = 0;

  logic [5:0] flg;
  assign flg = {f.full, f.empty, f.almost_full, f.almost_empty, f.overflow, f.underflow};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    f.wr = 1'b0; f.rd = 1'b0; f.flush_i = 1'b0; f.clr_err_i = 1'b0; rst_i = 1'b0;
  endtask

  task automatic test_reset;
    idle(); f.w_data = '0; rst_i = 1'b1;
    step(); rst_i = 1'b0;
    checks++; if (f.count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", f.count); end
    checks++; if (flg !== 6'b010100) begin failures++; $display("FAIL reset_flags got=%b exp=010100", flg); end
  endtask

  task automatic test_fill;
    logic [5:0] e;
    for (int i = 0; i < 16; i++) begin
      f.wr = 1'b1; f.w_data = 8'(i);
      step();
      e = {(i + 1 == 16), 1'b0, (i + 1 >= 14), (i + 1 <= 2), 2'b00};
      checks++; if (f.count !== 5'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, f.count, i + 1); end
      checks++; if (flg !== e) begin failures++; $display("FAIL fill_flags[%0d] got=%b exp=%b", i, flg, e); end
    end
    f.wr = 1'b0;
    checks++; if (f.r_data !== 8'h00) begin failures++; $display("FAIL fill_head got=%h exp=00", f.r_data); end
  endtask

  task automatic test_overflow;
    f.wr = 1'b1; f.w_data = 8'hAA;
    step(); f.wr = 1'b0;
    checks++; if (f.count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", f.count); end
    checks++; if (flg !== 6'b101010) begin failures++; $display("FAIL ovf_flags got=%b exp=101010", flg); end
    checks++; if (f.r_data !== 8'h00) begin failures++; $display("FAIL ovf_head got=%h exp=00", f.r_data); end
    f.clr_err_i = 1'b1;
    step(); f.clr_err_i = 1'b0;
    checks++; if (flg !== 6'b101000) begin failures++; $display("FAIL ovf_clear got=%b exp=101000", flg); end
  endtask

  task automatic test_drain;
    logic [5:0] e;
    for (int i = 0; i < 16; i++) begin
      checks++; if (f.r_data !== 8'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, f.r_data, 8'(i)); end
      f.rd = 1'b1;
      step();
      e = {1'b0, (15 - i == 0), (15 - i >= 14), (15 - i <= 2), 2'b00};
      checks++; if (f.count !== 5'(15 - i)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, f.count, 15 - i); end
      checks++; if (flg !== e) begin failures++; $display("FAIL drain_flags[%0d] got=%b exp=%b", i, flg, e); end
    end
    step(); f.rd = 1'b0;   // extra read on empty
    checks++; if (f.count !== 5'd0) begin failures++; $display("FAIL unf_count got=%0d exp=0", f.count); end
    checks++; if (flg !== 6'b010101) begin failures++; $display("FAIL unf_flags got=%b exp=010101", flg); end
    f.clr_err_i = 1'b1; step(); f.clr_err_i = 1'b0;
  endtask

  task automatic test_rw_edges;
    logic [7:0] exp_d;
    for (int i = 0; i < 16; i++) begin
      f.wr = 1'b1; f.w_data = 8'(8'h20 + i); step();
    end
    f.rd = 1'b1; f.w_data = 8'h55;
    step(); f.wr = 1'b0; f.rd = 1'b0;
    checks++; if (f.count !== 5'd16) begin failures++; $display("FAIL rwfull_count got=%0d exp=16", f.count); end
    checks++; if (flg !== 6'b101000) begin failures++; $display("FAIL rwfull_flags got=%b exp=101000", flg); end
    checks++; if (f.r_data !== 8'h21) begin failures++; $display("FAIL rwfull_head got=%h exp=21", f.r_data); end
    for (int j = 0; j < 16; j++) begin
      exp_d = (j < 15) ? 8'(8'h21 + j) : 8'h55;
      checks++; if (f.r_data !== exp_d) begin failures++; $display("FAIL rwfull_drain[%0d] got=%h exp=%h", j, f.r_data, exp_d); end
      f.rd = 1'b1; step(); f.rd = 1'b0;
    end
    f.rd = 1'b1; f.wr = 1'b1; f.w_data = 8'h77;
    step(); f.rd = 1'b0; f.wr = 1'b0;
    checks++; if (f.count !== 5'd1) begin failures++; $display("FAIL rwempty_count got=%0d exp=1", f.count); end
    checks++; if (flg !== 6'b000101) begin failures++; $display("FAIL rwempty_flags got=%b exp=000101", flg); end
    checks++; if (f.r_data !== 8'h77) begin failures++; $display("FAIL rwempty_head got=%h exp=77", f.r_data); end
    f.rd = 1'b1; step(); f.rd = 1'b0;
    f.clr_err_i = 1'b1; step(); f.clr_err_i = 1'b0;
    checks++; if (flg !== 6'b010100) begin failures++; $display("FAIL rwempty_clear got=%b exp=010100", flg); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 5; k++) begin
      f.wr = 1'b1; f.w_data = 8'(8'h80 + k); step();
    end
    for (int j = 0; j < 40; j++) begin
      checks++; if (f.r_data !== 8'(8'h80 + j)) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", j, f.r_data, 8'(8'h80 + j)); end
      f.wr = 1'b1; f.rd = 1'b1; f.w_data = 8'(8'h85 + j);
      step();
      checks++; if (f.count !== 5'd5) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=5", j, f.count); end
    end
    f.wr = 1'b0; f.rd = 1'b0;
  endtask

  task automatic test_flush;
    for (int k = 0; k < 4; k++) begin
      f.wr = 1'b1; f.w_data = 8'(k); step();
    end
    f.wr = 1'b0;
    checks++; if (f.count !== 5'd9) begin failures++; $display("FAIL flush_pre_count got=%0d exp=9", f.count); end
    f.flush_i = 1'b1; f.rd = 1'b1; f.wr = 1'b1;
    step();
    checks++; if (f.count !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", f.count); end
    checks++; if (flg !== 6'b010100) begin failures++; $display("FAIL flush_flags got=%b exp=010100", flg); end
    step();   // flush again while empty: rd/wr must not count or raise underflow
    checks++; if (f.count !== 5'd0) begin failures++; $display("FAIL flush_empty_count got=%0d exp=0", f.count); end
    checks++; if (flg !== 6'b010100) begin failures++; $display("FAIL flush_empty_flags got=%b exp=010100", flg); end
    f.flush_i = 1'b0; f.wr = 1'b0;
    step(); f.rd = 1'b0;
    checks++; if (flg !== 6'b010101) begin failures++; $display("FAIL flush_unf_set got=%b exp=010101", flg); end
    f.flush_i = 1'b1; f.rd = 1'b1; f.wr = 1'b1;
    step(); idle();
    checks++; if (flg !== 6'b010101) begin failures++; $display("FAIL flush_keeps_err got=%b exp=010101", flg); end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) begin
      f.wr = 1'b1; f.w_data = 8'(8'hC0 + k); step();
    end
    checks++; if (f.count !== 5'd3) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=3", f.count); end
    rst_i = 1'b1; f.rd = 1'b1;
    step(); idle();
    checks++; if (f.count !== 5'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", f.count); end
    checks++; if (flg !== 6'b010100) begin failures++; $display("FAIL rstmid_flags got=%b exp=010100", flg); end
    f.wr = 1'b1; f.w_data = 8'h3C;
    step(); f.wr = 1'b0;
    checks++; if (f.r_data !== 8'h3C) begin failures++; $display("FAIL rstmid_head got=%h exp=3c", f.r_data); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_rw_edges();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
